// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: round-robin N-to-1 stream merger with per-packet grant lock and registered output
module rr_arbiter_mux #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    localparam int SELECT_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS-1:0]            i_last,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_INPUTS-1:0]            o_ready,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_last,
    output logic [SELECT_BITS-1:0]           o_grant,
    input  logic                             i_ready
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic [SELECT_BITS-1:0] ptr, lk, win, sel;
    logic [SELECT_BITS:0] j;
    logic found, load, xfer;
    logic [DATA_WIDTH-1:0] data [NUM_INPUTS];
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_data
        assign data[k] = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end
    // scan from the far end back towards ptr so the closest requester wins
    always_comb begin
        win = '0;
        found = 1'b0;
        j = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            j = {1'b0, ptr} + (SELECT_BITS+1)'(i);
            j = (j >= (SELECT_BITS+1)'(NUM_INPUTS)) ? j - (SELECT_BITS+1)'(NUM_INPUTS) : j;
            if (i_valid[j[SELECT_BITS-1:0]]) begin
                win = j[SELECT_BITS-1:0];
                found = 1'b1;
            end
        end
    end
    assign load    = !o_valid || i_ready;
    assign sel     = (state == LOCKED) ? lk : win;
    assign xfer    = load && ((state == LOCKED) ? i_valid[sel] : found);
    assign o_ready = (load && (state == LOCKED || found)) ? NUM_INPUTS'(1) << sel : '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            lk      <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_grant <= '0;
        end else if (load) begin
            o_valid <= xfer;
            if (xfer) begin
                o_data  <= data[sel];
                o_last  <= i_last[sel];
                o_grant <= sel;
                lk      <= sel;
                state   <= i_last[sel] ? IDLE : LOCKED;
                if (i_last[sel])
                    ptr <= (sel == SELECT_BITS'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter_mux.sv
// tb_rr_arbiter_mux: directed and random checks of rr_arbiter_mux against a packet-level arbitration model
module tb_rr_arbiter_mux;
    localparam int N = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [N-1:0] valid, last, ready;
    logic [N*W-1:0] bus;
    logic ready_in, ov, ol;
    logic [W-1:0] od;
    logic [1:0] og;
    logic [2:0] v3, l3, r3;
    logic [23:0] d3;
    logic ov3, ol3;
    logic [7:0] od3;
    logic [1:0] og3;
    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    int m_owner = -1;
    int m_grant = 0;
    bit m_ov = 0;
    bit m_last = 0;
    logic [W-1:0] m_data = '0;
    int waits [N];
    int mk, cpk;
    bit mt;
    logic [N-1:0] cer;

    rr_arbiter_mux #(.NUM_INPUTS(N), .DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_last(last), .i_data_bus(bus),
        .o_ready(ready), .o_valid(ov), .o_data(od), .o_last(ol), .o_grant(og), .i_ready(ready_in)
    );
    rr_arbiter_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_last(l3), .i_data_bus(d3),
        .o_ready(r3), .o_valid(ov3), .o_data(od3), .o_last(ol3), .o_grant(og3), .i_ready(1'b1)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // owner if a packet is open, else first requester at or after the pointer
    function automatic int pick();
        if (m_owner >= 0) return m_owner;
        for (int o = 0; o < N; o++)
            if (valid[(m_ptr + o) % N]) return (m_ptr + o) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_owner = -1; m_ov = 0; m_data = '0; m_last = 0; m_grant = 0;
            for (int q = 0; q < N; q++) waits[q] = 0;
        end else begin
            mk = pick();
            mt = (!m_ov || ready_in) && mk >= 0 && valid[mk];
            for (int q = 0; q < N; q++) begin
                if (!valid[q] || (mt && mk == q)) waits[q] = 0;
                else if (mt && last[mk]) begin
                    waits[q]++;
                    chk("starve_bound", waits[q] > N - 1, 0);
                end
            end
            if (!m_ov || ready_in) begin
                m_ov = mt;
                if (mt) begin
                    m_data = bus[mk*W +: W];
                    m_last = last[mk];
                    m_grant = mk;
                    if (last[mk]) begin
                        m_owner = -1;
                        m_ptr = (mk + 1) % N;
                    end else m_owner = mk;
                end
            end
        end
    end

    always @(negedge clk) begin
        cpk = pick();
        cer = ((!m_ov || ready_in) && cpk >= 0) ? 4'(1) << cpk : '0;
        chk("m_ready", ready, cer);
        chk("m_valid", ov, m_ov);
        chk("m_data", od, m_data);
        chk("m_last", ol, m_last);
        chk("m_grant", og, m_grant);
    end

    initial begin
        valid = '0; last = '0; ready_in = 1'b1; v3 = '0; l3 = '0; d3 = 24'h332211;
        for (int q = 0; q < N; q++) bus[q*W +: W] = 32'h1000_0000 + q;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", ov, 0); chk("rst_grant", og, 0); chk("rst_data", od, 0);
        chk("rst_last", ol, 0); chk("rst_valid3", ov3, 0);
        // all inputs request single-beat packets
        @(posedge clk); #1 rst_n = 1'b1; valid = 4'hf; last = 4'hf;
        @(negedge clk); chk("t1_pre_valid", ov, 0); chk("t1_ready", ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_grant", og, i % 4); chk("t1_valid", ov, 1); chk("t1_data", od, 32'h1000_0000 + i % 4);
        end
        @(posedge clk); #1 valid = '0;
        @(negedge clk); chk("t1_tail", og, 1);
        // three-beat packet on input 2 while input 0 keeps requesting
        @(posedge clk); #1 valid = 4'b0101; last = 4'b0001; bus[64 +: 32] = 32'hB1;
        @(posedge clk); #1 bus[64 +: 32] = 32'hB2;
        @(negedge clk); chk("t2_b1_grant", og, 2); chk("t2_b1_data", od, 32'hB1); chk("t2_b1_last", ol, 0);
        @(posedge clk); #1 bus[64 +: 32] = 32'hB3; last = 4'b0101;
        @(negedge clk); chk("t2_b2_grant", og, 2); chk("t2_b2_data", od, 32'hB2); chk("t2_b2_last", ol, 0);
        @(posedge clk); #1 valid = 4'b0001;
        @(negedge clk); chk("t2_b3_grant", og, 2); chk("t2_b3_data", od, 32'hB3); chk("t2_b3_last", ol, 1);
        @(posedge clk); #1 valid = '0;
        @(negedge clk); chk("t2_next_grant", og, 0); chk("t2_next_data", od, 32'h1000_0000);
        // backpressure holds the output word
        @(posedge clk); #1 valid = 4'b0010; last = 4'b0010; bus[32 +: 32] = 32'hA5A5_A5A5;
        @(posedge clk); #1 ready_in = 1'b0; bus[32 +: 32] = 32'h5A5A_5A5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_valid", ov, 1); chk("t3_data", od, 32'hA5A5_A5A5); chk("t3_grant", og, 1);
            chk("t3_last", ol, 1); chk("t3_ready", ready, 0);
            @(posedge clk); #1 if (i == 4) ready_in = 1'b1;
        end
        @(posedge clk); #1 valid = '0;
        @(negedge clk); chk("t3_next_data", od, 32'h5A5A_5A5A); chk("t3_next_valid", ov, 1);
        // reset in the middle of a locked packet
        @(posedge clk); #1 valid = 4'b1000; last = '0;
        @(posedge clk); #1 valid = 4'b1011;
        @(negedge clk); chk("t5_lock_grant", og, 3); chk("t5_lock_ready", ready, 4'b1000);
        #1 rst_n = 1'b0;
        #1 chk("t5_rst_valid", ov, 0); chk("t5_rst_grant", og, 0); chk("t5_rst_data", od, 0);
        @(posedge clk); #1 rst_n = 1'b1; valid = 4'hf; last = 4'hf;
        @(posedge clk); #1 valid = '0;
        @(negedge clk); chk("t5_after_grant", og, 0);
        // three-input instance: pointer wraps from 2 back to 0
        @(posedge clk); #1 v3 = 3'b010; l3 = 3'b111;
        @(posedge clk); #1 v3 = 3'b100;
        @(negedge clk); chk("t4_grant1", og3, 1);
        @(posedge clk); #1 v3 = 3'b011;
        @(negedge clk); chk("t4_grant2", og3, 2); chk("t4_ready", r3, 3'b001);
        @(posedge clk); #1 v3 = '0;
        @(negedge clk); chk("t4_wrap_grant", og3, 0); chk("t4_wrap_data", od3, 8'h11);
        // random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1
            valid = N'($urandom);
            last = N'($urandom);
            ready_in = ($urandom % 4) != 0;
            for (int q = 0; q < N; q++) bus[q*W +: W] = $urandom;
        end
        @(posedge clk); #1 valid = '0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
